// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: waiting for a request, or locked onto one channel
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF      = 2;
    localparam int DW_DEF        = 8;
    localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    // Scan from the farthest candidate back to ptr so the closest one wins last
    always_comb begin
        logic [IW:0]   w_sum;
        logic [IW-1:0] w_idx;
        gnt_id = '0;
        any    = |req;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_idx = w_sum[IW-1:0];
            if (req[w_idx]) begin
                gnt_id = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between NREQ valid/ready producers with
// round-robin, burst-locked grants and full-flag backpressure.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_we,
    output logic [DW-1:0]           fifo_wdata,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int IW  = $clog2(NREQ);
    localparam int BCW = $clog2(BURST_LEN + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);
    localparam logic [IW-1:0]  MAX_ID    = IW'(NREQ - 1);

    arb_state_t     r_state;
    arb_state_t     w_stateNext;
    logic [IW-1:0]  r_rrPtr;
    logic [IW-1:0]  w_rrPtrNext;
    logic [IW-1:0]  r_grantId;
    logic [IW-1:0]  w_grantIdNext;
    logic [BCW-1:0] r_beatCnt;
    logic [BCW-1:0] w_beatCntNext;
    logic [IW-1:0]  w_winner;
    logic           w_any;
    logic           w_xfer;
    logic [IW-1:0]  w_ptrAfterGrant;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (r_rrPtr),
        .gnt_id (w_winner),
        .any    (w_any)
    );

    // Pointer value that hands priority to the channel after the current one
    always_comb begin
        w_ptrAfterGrant = (r_grantId == MAX_ID) ? '0 : r_grantId + 1'b1;
    end

    // Next-state and handshake decode; write path is a zero-latency pass-through
    always_comb begin
        w_stateNext   = r_state;
        w_rrPtrNext   = r_rrPtr;
        w_grantIdNext = r_grantId;
        w_beatCntNext = r_beatCnt;
        w_xfer        = 1'b0;
        req_ready     = '0;
        fifo_we       = 1'b0;
        fifo_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grantIdNext = w_winner;
                    w_beatCntNext = '0;
                    w_stateNext   = LOCK;
                end
            end
            LOCK: begin
                req_ready[r_grantId] = ~fifo_full;
                w_xfer  = req_valid[r_grantId] & ~fifo_full;
                fifo_we = w_xfer;
                if (w_xfer) begin
                    fifo_wdata = req_data[r_grantId*DW +: DW];
                    if (req_last[r_grantId] || (r_beatCnt == LAST_BEAT)) begin
                        w_stateNext   = IDLE;
                        w_rrPtrNext   = w_ptrAfterGrant;
                        w_beatCntNext = '0;
                    end else begin
                        w_beatCntNext = r_beatCnt + 1'b1;
                    end
                end else if (!req_valid[r_grantId]) begin
                    // Producer went away: give the port up rather than wait
                    w_stateNext = IDLE;
                    w_rrPtrNext = w_ptrAfterGrant;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_grantId <= '0;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_rrPtr   <= w_rrPtrNext;
            r_grantId <= w_grantIdNext;
            r_beatCnt <= w_beatCntNext;
        end
    end

    // Status outputs straight from the registers
    always_comb begin
        grant_id = r_grantId;
        busy     = (r_state == LOCK);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=2, DW=8, BURST_LEN=4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid;
    logic [15:0] reqData;
    logic [1:0]  reqLast;
    logic [1:0]  reqReady;
    logic        fifoFull;
    logic        fifoWe;
    logic [7:0]  fifoWdata;
    logic [0:0]  grantId;
    logic        busy;

    int nChecks = 0;
    int nFail   = 0;

    fifo_wr_arbiter #(
        .NREQ      (2),
        .DW        (8),
        .BURST_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_data   (reqData),
        .req_last   (reqLast),
        .req_ready  (reqReady),
        .fifo_full  (fifoFull),
        .fifo_we    (fifoWe),
        .fifo_wdata (fifoWdata),
        .grant_id   (grantId),
        .busy       (busy)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst      = 1'b0;
        reqValid = 2'b00;
        reqLast  = 2'b00;
        reqData  = 16'h0000;
        fifoFull = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        reqValid = 2'b11;
        reqLast  = 2'b00;
        reqData  = 16'h5AA5;
        fifoFull = 1'b0;
        tick();
        tick();
        #2;
        nChecks++; if (reqReady !== 2'b00) begin nFail++; $display("[TB] FAIL reset_ready: got %b required 00", reqReady); end
        nChecks++; if (fifoWe !== 1'b0) begin nFail++; $display("[TB] FAIL reset_we: got %b required 0", fifoWe); end
        nChecks++; if (fifoWdata !== 8'h00) begin nFail++; $display("[TB] FAIL reset_wdata: got %h required 00", fifoWdata); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        nChecks++; if (grantId !== 1'b0) begin nFail++; $display("[TB] FAIL reset_grant: got %b required 0", grantId); end
    endtask

    task automatic test_single;
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        doReset();
        reqValid = 2'b01;
        reqData  = {8'h00, beats[0]};
        #2;
        nChecks++; if (fifoWe !== 1'b0) begin nFail++; $display("[TB] FAIL single_idle_we: got %b required 0", fifoWe); end
        for (int i = 0; i < 3; i++) begin
            tick();
            reqData = {8'h00, beats[i]};
            reqLast = (i == 2) ? 2'b01 : 2'b00;
            #2;
            nChecks++; if (fifoWe !== 1'b1) begin nFail++; $display("[TB] FAIL single_we%0d: got %b required 1", i, fifoWe); end
            nChecks++; if (fifoWdata !== beats[i]) begin nFail++; $display("[TB] FAIL single_data%0d: got %h required %h", i, fifoWdata, beats[i]); end
            nChecks++; if (reqReady !== 2'b01) begin nFail++; $display("[TB] FAIL single_ready%0d: got %b required 01", i, reqReady); end
        end
        tick();
        reqValid = 2'b00;
        reqLast  = 2'b00;
        #2;
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL single_idle_after: busy got %b required 0", busy); end
        nChecks++; if (fifoWe !== 1'b0) begin nFail++; $display("[TB] FAIL single_we_after: got %b required 0", fifoWe); end
    endtask

    task automatic test_back_to_back;
        logic       expWe;
        logic       expG;
        logic [7:0] expData;
        doReset();
        reqValid = 2'b11;
        reqData  = {8'h5A, 8'hA5};
        for (int cyc = 0; cyc < 15; cyc++) begin
            #2;
            expWe   = (cyc % 5) != 0;
            expG    = ((cyc / 5) % 2) == 1;
            expData = expWe ? (expG ? 8'h5A : 8'hA5) : 8'h00;
            nChecks++; if (fifoWe !== expWe) begin nFail++; $display("[TB] FAIL b2b_we c%0d: got %b required %b", cyc, fifoWe, expWe); end
            nChecks++; if (fifoWdata !== expData) begin nFail++; $display("[TB] FAIL b2b_data c%0d: got %h required %h", cyc, fifoWdata, expData); end
            if (expWe) begin
                nChecks++; if (grantId !== expG) begin nFail++; $display("[TB] FAIL b2b_grant c%0d: got %b required %b", cyc, grantId, expG); end
            end
            tick();
        end
        reqValid = 2'b00;
    endtask

    task automatic test_full;
        int         accepted;
        logic       inBurst;
        logic       expWe;
        logic [1:0] expReady;
        accepted = 0;
        doReset();
        reqValid = 2'b10;
        for (int c = 0; c < 9; c++) begin
            fifoFull = (c >= 3) && (c <= 5);
            reqData  = {8'hC0 + 8'(accepted), 8'h00};
            #2;
            inBurst  = (c >= 1) && (c <= 7);
            expWe    = inBurst && !fifoFull;
            expReady = expWe ? 2'b10 : 2'b00;
            nChecks++; if (fifoWe !== expWe) begin nFail++; $display("[TB] FAIL full_we c%0d: got %b required %b", c, fifoWe, expWe); end
            nChecks++; if (reqReady !== expReady) begin nFail++; $display("[TB] FAIL full_ready c%0d: got %b required %b", c, reqReady, expReady); end
            nChecks++; if (busy !== inBurst) begin nFail++; $display("[TB] FAIL full_busy c%0d: got %b required %b", c, busy, inBurst); end
            if (expWe) begin
                nChecks++; if (fifoWdata !== 8'hC0 + 8'(accepted)) begin nFail++; $display("[TB] FAIL full_data c%0d: got %h required %h", c, fifoWdata, 8'hC0 + 8'(accepted)); end
            end
            if (reqValid[1] && reqReady[1]) accepted++;
            tick();
        end
        fifoFull = 1'b0;
        reqValid = 2'b00;
        nChecks++; if (accepted !== 4) begin nFail++; $display("[TB] FAIL full_beats: got %0d required 4", accepted); end
    endtask

    task automatic test_last_full;
        doReset();
        reqValid = 2'b01;
        reqLast  = 2'b01;
        reqData  = 16'h003C;
        fifoFull = 1'b1;
        #2;
        tick();
        for (int c = 1; c < 3; c++) begin
            #2;
            nChecks++; if (fifoWe !== 1'b0) begin nFail++; $display("[TB] FAIL lastfull_we c%0d: got %b required 0", c, fifoWe); end
            nChecks++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL lastfull_busy c%0d: got %b required 1", c, busy); end
            tick();
        end
        fifoFull = 1'b0;
        #2;
        nChecks++; if (fifoWe !== 1'b1) begin nFail++; $display("[TB] FAIL lastfull_write: got %b required 1", fifoWe); end
        nChecks++; if (fifoWdata !== 8'h3C) begin nFail++; $display("[TB] FAIL lastfull_data: got %h required 3c", fifoWdata); end
        tick();
        #2;
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL lastfull_release: busy got %b required 0", busy); end
        reqValid = 2'b00;
        reqLast  = 2'b00;
    endtask

    task automatic test_drop;
        doReset();
        reqValid = 2'b11;
        reqData  = {8'h66, 8'h99};
        #2;
        tick();
        #2;
        nChecks++; if (fifoWe !== 1'b1 || fifoWdata !== 8'h99) begin nFail++; $display("[TB] FAIL drop_first: got we=%b data=%h required we=1 data=99", fifoWe, fifoWdata); end
        tick();
        reqValid = 2'b10;
        #2;
        nChecks++; if (fifoWe !== 1'b0 || busy !== 1'b1) begin nFail++; $display("[TB] FAIL drop_release: got we=%b busy=%b required we=0 busy=1", fifoWe, busy); end
        tick();
        #2;
        nChecks++; if (busy !== 1'b0 || fifoWe !== 1'b0) begin nFail++; $display("[TB] FAIL drop_bubble: got busy=%b we=%b required 0 0", busy, fifoWe); end
        tick();
        #2;
        nChecks++; if (grantId !== 1'b1) begin nFail++; $display("[TB] FAIL drop_grant: got %b required 1", grantId); end
        nChecks++; if (fifoWe !== 1'b1 || fifoWdata !== 8'h66) begin nFail++; $display("[TB] FAIL drop_ch1: got we=%b data=%h required we=1 data=66", fifoWe, fifoWdata); end
        reqValid = 2'b00;
    endtask

    task automatic test_async_reset;
        doReset();
        reqValid = 2'b01;
        reqLast  = 2'b01;
        reqData  = {8'h88, 8'h77};
        #2;
        tick();
        #2;
        tick();
        reqValid = 2'b10;
        reqLast  = 2'b00;
        #2;
        tick();
        tick();
        tick();
        #2;
        nChecks++; if (fifoWe !== 1'b1 || grantId !== 1'b1) begin nFail++; $display("[TB] FAIL areset_pre: got we=%b grant=%b required we=1 grant=1", fifoWe, grantId); end
        rst = 1'b0;
        #1;
        nChecks++; if (fifoWe !== 1'b0 || reqReady !== 2'b00) begin nFail++; $display("[TB] FAIL areset_now: got we=%b ready=%b required 0 00", fifoWe, reqReady); end
        nChecks++; if (busy !== 1'b0 || grantId !== 1'b0 || fifoWdata !== 8'h00) begin nFail++; $display("[TB] FAIL areset_state: got busy=%b grant=%b data=%h required 0 0 00", busy, grantId, fifoWdata); end
        reqValid = 2'b11;
        tick();
        rst = 1'b1;
        #2;
        nChecks++; if (fifoWe !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL areset_idle: got we=%b busy=%b required 0 0", fifoWe, busy); end
        tick();
        #2;
        nChecks++; if (grantId !== 1'b0 || fifoWdata !== 8'h77) begin nFail++; $display("[TB] FAIL areset_winner: got grant=%b data=%h required 0 77", grantId, fifoWdata); end
        reqValid = 2'b00;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_last_full();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit `fifo` between NREQ producer channels.
- Round-robin grant; each grant is locked for a burst of up to BURST_LEN beats.
- Each producer channel uses a valid/ready handshake.
- FIFO backpressure (`full`) stalls the granted channel without losing data.
- Sits between producer logic (e.g. UART RX, button/event sources) and the FIFO `we`/`wdata` inputs, in the FIFO write-clock domain.

Parameters:
- NREQ, 2, number of requesting channels (2..4).
- DW, 8, data width; matches FIFO `wdata`.
- BURST_LEN, 4, maximum beats per grant (1..16).

Ports:
- clk  input  1  single clock; drives the FIFO `wclk`.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  channel i has a beat on req_data.
- req_data  input  NREQ*DW  packed; channel i occupies bits [i*DW +: DW].
- req_last  input  NREQ  current beat of channel i ends its burst.
- req_ready  output  NREQ  beat of channel i accepted this cycle when valid&ready.
- fifo_full  input  1  FIFO `full` flag.
- fifo_we  output  1  FIFO write enable.
- fifo_wdata  output  DW  FIFO write data.
- grant_id  output  $clog2(NREQ)  currently granted channel.
- busy  output  1  1 while in LOCK.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - req_ready=0, fifo_we=0, fifo_wdata=0, busy=0.
  - Reset mid-burst aborts the burst; no partial write is issued in the reset cycle.
- FSM states: IDLE, LOCK.
- IDLE:
  - req_ready=0, fifo_we=0.
  - If any req_valid: winner = first set req_valid searching from rr_ptr upward, mod NREQ.
  - On the next edge: grant_id<=winner, beat_cnt<=0, state<=LOCK.
  - With no valid, stay in IDLE.
- LOCK (g = grant_id):
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - xfer = req_valid[g] & ~fifo_full.
  - fifo_we = xfer.
  - fifo_wdata = req_data[g] when xfer, else 0. Combinational, zero-latency pass-through.
  - On xfer with (req_last[g] | beat_cnt==BURST_LEN-1): state<=IDLE, rr_ptr<=(g+1) mod NREQ, beat_cnt<=0.
  - On xfer otherwise: beat_cnt<=beat_cnt+1.
  - req_valid[g]=0 (no xfer): release. state<=IDLE, rr_ptr<=(g+1) mod NREQ. Producers must not drop valid mid-burst expecting to keep the grant.
  - fifo_full=1 with valid: stall. beat_cnt, grant and state are held; the producer must hold data stable.
- Latency:
  - First beat of a burst is written 1 cycle after req_valid is first seen in IDLE.
  - Exactly one IDLE bubble cycle follows every release.
- Fairness:
  - A continuously requesting channel waits at most (NREQ-1) bursts + (NREQ-1) bubble cycles, excluding full stalls.
  - rr_ptr wraps NREQ-1 -> 0.
- Width rules:
  - beat_cnt width = $clog2(BURST_LEN+1); it never exceeds BURST_LEN-1.
  - grant_id and rr_ptr are unsigned mod NREQ.
- Invariants:
  - fifo_we implies ~fifo_full.
  - At most one req_ready bit is set.
  - fifo_we == |(req_valid & req_ready).
- Simultaneous events:
  - Last beat and fifo_full in the same cycle: no xfer, so no release; the release happens on the cycle the beat is actually written.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, LOCK} arb_state_t.
  - Default constants NREQ_DEF=2, DW_DEF=8, BURST_LEN_DEF=4.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: gnt_id, any.
  - Instantiated once and reused by the verification model.

Test Plan:
- Reset hold, rst=0 with all req_valid=1 -> req_ready=0, fifo_we=0, fifo_wdata=0, busy=0, grant_id=0.
- Single channel: ch0 sends 0x11,0x22,0x33 with req_last on 0x33 -> fifo_we high 3 consecutive cycles starting 1 cycle after valid; data in order; IDLE follows.
- Both channels always valid, BURST_LEN=4, no last -> write order ch0 x4, bubble, ch1 x4, bubble, ch0 x4; grant_id toggles 0,1,0.
- fifo_full asserted for 3 cycles mid-burst at beat 2 of ch1 -> fifo_we=0 and req_ready=0 for those cycles; beat_cnt held at 2; burst resumes and ends after beat 4 total; no beat lost or duplicated.
- ch0 drops valid after 1 beat, ch1 waiting -> release, 1 bubble, ch1 granted next (rr_ptr=1).
- Async reset pulse during LOCK at beat 2 -> outputs zero immediately without a clock edge; after release ch0 wins first (rr_ptr=0).
